// File: rtl/round_robin_fifo_dispatcher_pkg.sv
// Shared types and constants for the round-robin FIFO dispatcher.
// Imported by the queue, the interface users and the top.
package dispatcher_pkg;

  localparam int NUM_Q     = 4;
  localparam int DEF_DEPTH = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEF_PTR_W = ptr_w(DEF_DEPTH);

  typedef logic [1:0]           qidx_t;
  typedef logic [DEF_PTR_W:0]   count_t;

endpackage

// File: rtl/round_robin_fifo_dispatcher_if.sv
// Producer/consumer bundle for the dispatcher.
// Handshake: one word is offered per cycle with wen; it is taken or dropped
// (drop pulses next cycle). ren[i] pops queue i; valid[i] marks dout_i the cycle after.
interface round_robin_fifo_dispatcher_if #(
  parameter int DATA_W = 8
);
  logic              wen;
  logic [DATA_W-1:0] din;
  logic [3:0]        ren;
  logic [DATA_W-1:0] dout_a;
  logic [DATA_W-1:0] dout_b;
  logic [DATA_W-1:0] dout_c;
  logic [DATA_W-1:0] dout_d;
  logic [3:0]        valid;
  logic [3:0]        full;
  logic [3:0]        empty;
  logic [1:0]        target;
  logic              drop;

  modport master (
    output wen, din, ren,
    input  dout_a, dout_b, dout_c, dout_d, valid, full, empty, target, drop
  );

  modport slave (
    input  wen, din, ren,
    output dout_a, dout_b, dout_c, dout_d, valid, full, empty, target, drop
  );
endinterface

// File: rtl/round_robin_fifo_dispatcher_fifo_q.sv
// Single-clock DEPTH x DATA_W queue with registered read data and valid.
// Pushes to a full queue and pops from an empty queue are ignored.
module fifo_q
  import dispatcher_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = ptr_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage carries no reset; only pointers and count define content.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        dout   <= mem[rd_ptr];
        valid  <= 1'b1;
      end else begin
        dout   <= '0;
        valid  <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/round_robin_fifo_dispatcher.sv
// Spreads one write stream over four queues in round-robin order.
// DISPATCH_SKIP_FULL_EN: skip full queues instead of dropping on a full target.
module round_robin_fifo_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  round_robin_fifo_dispatcher_if.slave  bus
);
  qidx_t             target;
  qidx_t             target_d;
  qidx_t             chosen;
  logic              accept;
  logic              drop_q;
  logic [NUM_Q-1:0]  push;
  logic [NUM_Q-1:0]  full;
  logic [NUM_Q-1:0]  empty;
  logic [NUM_Q-1:0]  valid;
  logic [DATA_W-1:0] dout [NUM_Q];

`ifdef DISPATCH_SKIP_FULL_EN
  qidx_t cand;

  // First non-full queue at or after target wins; target moves past it.
  always_comb begin
    chosen = target;
    accept = 1'b0;
    cand   = target;
    for (int k = 0; k < NUM_Q; k++) begin
      cand = target + qidx_t'(k);
      if (bus.wen && !accept && !full[cand]) begin
        accept = 1'b1;
        chosen = cand;
      end
    end
    target_d = accept ? qidx_t'(chosen + qidx_t'(1)) : target;
  end
`else
  // Strict rotation: target advances on every write, accepted or not.
  always_comb begin
    chosen   = target;
    accept   = bus.wen & ~full[target];
    target_d = bus.wen ? qidx_t'(target + qidx_t'(1)) : target;
  end
`endif

  always_comb begin
    push = '0;
    if (accept) push[chosen] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= '0;
      drop_q <= 1'b0;
    end else begin
      target <= target_d;
      drop_q <= bus.wen & ~accept;
    end
  end

  for (genvar i = 0; i < NUM_Q; i++) begin : g_q
    fifo_q #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_q (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (bus.din),
      .pop   (bus.ren[i]),
      .dout  (dout[i]),
      .valid (valid[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign bus.dout_a = dout[0];
  assign bus.dout_b = dout[1];
  assign bus.dout_c = dout[2];
  assign bus.dout_d = dout[3];
  assign bus.valid  = valid;
  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.target = target;
  assign bus.drop   = drop_q;
endmodule

// File: tb/tb_round_robin_fifo_dispatcher.sv
// Directed bench for round_robin_fifo_dispatcher: vector table plus
// hand sequences for the full-queue and mid-stream reset corners.
module tb_round_robin_fifo_dispatcher;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  round_robin_fifo_dispatcher_if #(.DATA_W(8)) bus ();

  round_robin_fifo_dispatcher #(.DATA_W(8), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wen;
    logic [7:0] din;
    logic [3:0] ren;
    logic [3:0] valid;
    logic [7:0] da;
    logic [7:0] db;
    logic [7:0] dc;
    logic [7:0] dd;
    logic [1:0] target;
    logic [3:0] empty;
    logic [3:0] full;
    logic       drop;
  } vec_t;

  vec_t vecs [19];
  logic [7:0] exp_q [4][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic [3:0] r);
    bus.wen = w;
    bus.din = d;
    bus.ren = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic [7:0] d, input logic [3:0] r,
                              input logic [3:0] v, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] e, input logic [1:0] t,
                              input logic [3:0] em);
    vec_t x;
    x.wen = w; x.din = d; x.ren = r; x.valid = v;
    x.da = a; x.db = b; x.dc = c; x.dd = e;
    x.target = t; x.empty = em; x.full = 4'b0000; x.drop = 1'b0;
    return x;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 8'd0, 4'b0000);

    //            wen din     ren      valid    a      b      c      d      tgt   empty
    vecs[0]  = mk(1, 8'd87, 4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd1, 4'b1110);
    vecs[1]  = mk(1, 8'd56, 4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd2, 4'b1100);
    vecs[2]  = mk(1, 8'd9,  4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd3, 4'b1000);
    vecs[3]  = mk(1, 8'd12, 4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd0, 4'b0000);
    vecs[4]  = mk(1, 8'd85, 4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd1, 4'b0000);
    vecs[5]  = mk(0, 8'd0,  4'b1111, 4'b1111, 8'd87, 8'd56, 8'd9,  8'd12, 2'd1, 4'b1110);
    vecs[6]  = mk(0, 8'd0,  4'b0001, 4'b0001, 8'd85, 8'd0,  8'd0,  8'd0,  2'd1, 4'b1111);
    vecs[7]  = mk(0, 8'd0,  4'b0100, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd1, 4'b1111);
    vecs[8]  = mk(1, 8'd20, 4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd2, 4'b1101);
    vecs[9]  = mk(1, 8'd30, 4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd3, 4'b1001);
    vecs[10] = mk(1, 8'd40, 4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd0, 4'b0001);
    vecs[11] = mk(1, 8'd77, 4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd1, 4'b0000);
    vecs[12] = mk(1, 8'd1,  4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd2, 4'b0000);
    vecs[13] = mk(1, 8'd2,  4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd3, 4'b0000);
    vecs[14] = mk(1, 8'd3,  4'b0000, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  2'd0, 4'b0000);
    vecs[15] = mk(1, 8'd51, 4'b0001, 4'b0001, 8'd77, 8'd0,  8'd0,  8'd0,  2'd1, 4'b0000);
    vecs[16] = mk(0, 8'd0,  4'b0001, 4'b0001, 8'd51, 8'd0,  8'd0,  8'd0,  2'd1, 4'b0001);
    vecs[17] = mk(0, 8'd0,  4'b1110, 4'b1110, 8'd0,  8'd20, 8'd30, 8'd40, 2'd1, 4'b0001);
    vecs[18] = mk(0, 8'd0,  4'b1110, 4'b1110, 8'd0,  8'd1,  8'd2,  8'd3,  2'd1, 4'b1111);

    // reset state
    #12;
    chk("rst_target", 32'(bus.target), 32'd0);
    chk("rst_empty",  32'(bus.empty),  32'hF);
    chk("rst_full",   32'(bus.full),   32'h0);
    chk("rst_valid",  32'(bus.valid),  32'h0);
    chk("rst_drop",   32'(bus.drop),   32'd0);
    chk("rst_dout",   {bus.dout_a, bus.dout_b, bus.dout_c, bus.dout_d}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].wen, vecs[i].din, vecs[i].ren);
      step();
      chk($sformatf("v%0d_valid", i),  32'(bus.valid),  32'(vecs[i].valid));
      chk($sformatf("v%0d_dout_a", i), 32'(bus.dout_a), 32'(vecs[i].da));
      chk($sformatf("v%0d_dout_b", i), 32'(bus.dout_b), 32'(vecs[i].db));
      chk($sformatf("v%0d_dout_c", i), 32'(bus.dout_c), 32'(vecs[i].dc));
      chk($sformatf("v%0d_dout_d", i), 32'(bus.dout_d), 32'(vecs[i].dd));
      chk($sformatf("v%0d_target", i), 32'(bus.target), 32'(vecs[i].target));
      chk($sformatf("v%0d_empty", i),  32'(bus.empty),  32'(vecs[i].empty));
      chk($sformatf("v%0d_full", i),   32'(bus.full),   32'(vecs[i].full));
      chk($sformatf("v%0d_drop", i),   32'(bus.drop),   32'(vecs[i].drop));
    end

    // fill every queue to DEPTH starting from target 1
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 8'(100 + i), 4'b0000);
      exp_q[(1 + i) % 4].push_back(8'(100 + i));
      step();
    end
    drive(1'b0, 8'd0, 4'b0000);
    chk("fill_full",   32'(bus.full),   32'hF);
    chk("fill_empty",  32'(bus.empty),  32'h0);
    chk("fill_target", 32'(bus.target), 32'd1);
    chk("fill_drop",   32'(bus.drop),   32'd0);

    // make room in queue c only
    drive(1'b0, 8'd0, 4'b0100);
    step();
    chk("popc_valid", 32'(bus.valid),  32'b0100);
    chk("popc_dout",  32'(bus.dout_c), 32'(exp_q[2].pop_front()));
    chk("popc_full",  32'(bus.full),   32'b1011);

    // write with target=1 pointing at full queue b
    drive(1'b1, 8'd139, 4'b0000);
    step();
`ifdef DISPATCH_SKIP_FULL_EN
    exp_q[2].push_back(8'd139);
    chk("skip_drop",   32'(bus.drop),   32'd0);
    chk("skip_target", 32'(bus.target), 32'd3);
    chk("skip_full",   32'(bus.full),   32'hF);
    drive(1'b1, 8'd200, 4'b0000);
    step();
    chk("allfull_drop",   32'(bus.drop),   32'd1);
    chk("allfull_target", 32'(bus.target), 32'd3);
    drive(1'b0, 8'd0, 4'b0000);
    step();
    chk("allfull_drop_end", 32'(bus.drop), 32'd0);
`else
    chk("strict_drop",   32'(bus.drop),   32'd1);
    chk("strict_target", 32'(bus.target), 32'd2);
    chk("strict_full",   32'(bus.full),   32'b1011);
    drive(1'b0, 8'd0, 4'b0000);
    step();
    chk("strict_drop_end",   32'(bus.drop),   32'd0);
    chk("strict_target_end", 32'(bus.target), 32'd2);
`endif

    // drain b and c against the scoreboard
    for (int k = 0; k < 8; k++) begin
      logic eb, ec;
      logic [7:0] xb, xc;
      eb = (exp_q[1].size() != 0);
      ec = (exp_q[2].size() != 0);
      xb = eb ? exp_q[1].pop_front() : 8'd0;
      xc = ec ? exp_q[2].pop_front() : 8'd0;
      drive(1'b0, 8'd0, 4'b0110);
      step();
      chk($sformatf("drain%0d_valid", k), 32'(bus.valid),  32'({1'b0, ec, eb, 1'b0}));
      chk($sformatf("drain%0d_dout_b", k), 32'(bus.dout_b), 32'(xb));
      chk($sformatf("drain%0d_dout_c", k), 32'(bus.dout_c), 32'(xc));
    end
    drive(1'b0, 8'd0, 4'b0000);
    chk("drain_empty", 32'(bus.empty), 32'b0110);

    // half-cycle reset while a and d still hold data
    rst = 1'b1;
    #1;
    chk("midrst_empty",  32'(bus.empty),  32'hF);
    chk("midrst_full",   32'(bus.full),   32'h0);
    chk("midrst_valid",  32'(bus.valid),  32'h0);
    chk("midrst_target", 32'(bus.target), 32'd0);
    chk("midrst_drop",   32'(bus.drop),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'd5, 4'b0000);
    step();
    drive(1'b0, 8'd0, 4'b0001);
    chk("post_target", 32'(bus.target), 32'd1);
    chk("post_empty",  32'(bus.empty),  32'b1110);
    step();
    drive(1'b0, 8'd0, 4'b0000);
    chk("post_dout_a", 32'(bus.dout_a), 32'd5);
    chk("post_valid",  32'(bus.valid),  32'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
